// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver with mid-bit sampling.
//
// The serial input is synchronised through two flops (rx_s). A falling rx_s in
// IDLE arms a half-bit timer. The start bit is re-checked at its centre, and
// then each data bit and the stop bit are sampled one full bit period apart.
// A good stop bit publishes the byte with a one-cycle rcv strobe. A low stop
// bit raises a one-cycle ferr strobe and parks in BREAK until the line idles.
//
// Parameters:
//   BAUD  clock cycles per serial bit. The default of 104 gives 115200 baud
//         at 12 MHz. BAUD must be at least 4.
//
// Ports:
//   clk   in   system clock; all logic runs on the rising edge
//   rst   in   synchronous, active-high reset
//   rx    in   asynchronous serial line; idles high
//   data  out  last correctly received byte (holds between frames)
//   rcv   out  one-cycle pulse when data is updated
//   ferr  out  one-cycle pulse when the stop bit is sampled low
//   busy  out  high from start detect until the end of the frame
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int BAUD = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rcv,
    output logic       ferr,
    output logic       busy
);

    localparam int CW = $clog2(BAUD) + 1;
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] LOAD_HALF = CW'(BAUD / 2 - 1);
    localparam logic [CW-1:0] LOAD_FULL = CW'(BAUD - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t          state_q;
    logic [1:0]      sync_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic [7:0]      data_q;
    logic            rcv_q;
    logic            ferr_q;
    logic            busy_q;

    logic            rx_s;
    logic            tick_s;

    assign rx_s   = sync_q[1];
    // A tick is the cycle in which the timer has run down to zero.
    assign tick_s = (cnt_q == CNT_ZERO);

    assign data = data_q;
    assign rcv  = rcv_q;
    assign ferr = ferr_q;
    assign busy = busy_q;

    // Synchroniser, bit timer and receive FSM with registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sync_q    <= 2'b11;
            cnt_q     <= CNT_ZERO;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            rcv_q     <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], rx};
            rcv_q  <= 1'b0;
            ferr_q <= 1'b0;
            // The timer rests at zero rather than wrapping in the waiting states.
            if (cnt_q != CNT_ZERO) begin
                cnt_q <= cnt_q - CNT_ONE;
            end else begin
                cnt_q <= CNT_ZERO;
            end

            case (state_q)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    if (!rx_s) begin
                        state_q <= S_START;
                        cnt_q   <= LOAD_HALF;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end

                S_START: begin
                    if (tick_s) begin
                        if (!rx_s) begin
                            state_q   <= S_DATA;
                            cnt_q     <= LOAD_FULL;
                            bit_idx_q <= 3'd0;
                        end else begin
                            // Start bit did not hold to its centre: a glitch.
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        state_q <= S_START;
                    end
                end

                S_DATA: begin
                    if (tick_s) begin
                        // LSB arrives first, so shift right from the top.
                        shift_q   <= {rx_s, shift_q[7:1]};
                        cnt_q     <= LOAD_FULL;
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= S_STOP;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end else begin
                        state_q <= S_DATA;
                    end
                end

                S_STOP: begin
                    if (tick_s) begin
                        if (rx_s) begin
                            data_q  <= shift_q;
                            rcv_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            // Back in IDLE half a bit early, so a start bit
                            // that directly follows is caught.
                            state_q <= S_IDLE;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= S_BREAK;
                        end
                    end else begin
                        state_q <= S_STOP;
                    end
                end

                S_BREAK: begin
                    busy_q <= 1'b1;
                    // A line held low must idle before another frame is armed.
                    if (rx_s) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= S_BREAK;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    localparam int BAUD = 104;
    // Latency from driving the start edge on rx to rcv being visible:
    // 2 synchroniser cycles, then BAUD/2 + 9*BAUD + 1.
    localparam int LAT = 2 + BAUD / 2 + 9 * BAUD + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       rcv;
    logic       ferr;
    logic       busy;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Monitor state
    logic [7:0] rcv_d[$];
    int         rcv_t[$];
    int         ferr_n    = 0;
    int         both_n    = 0;
    int         win_lo    = -1;
    int         win_hi    = -1;
    int         busy_low  = 0;

    uart_rx #(.BAUD(BAUD)) dut (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .data (data),
        .rcv  (rcv),
        .ferr (ferr),
        .busy (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (rcv) begin
                rcv_d.push_back(data);
                rcv_t.push_back(cyc);
            end
            if (ferr) ferr_n = ferr_n + 1;
            if (rcv && ferr) both_n = both_n + 1;
            if (cyc >= win_lo && cyc <= win_hi && !busy) busy_low = busy_low + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        rcv_d.delete();
        rcv_t.delete();
        ferr_n = 0;
    endtask

    // Drive one frame starting at the current negedge; t0 = cycle of start edge.
    task automatic send_frame(input logic [7:0] b, input int per, input logic stop_v,
                              input int extra_low, output int t0);
        t0 = cyc;
        rx = 1'b0;
        repeat (per) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (per) @(negedge clk);
        end
        rx = stop_v;
        repeat (per + extra_low) @(negedge clk);
        rx = 1'b1;
    endtask

    initial begin
        int t0, t1, gap, per;
        logic [7:0] b;
        logic [7:0] exp_q[$];

        // Reset state
        rst = 1'b1;
        rx  = 1'b1;
        repeat (4) @(negedge clk);
        chk("reset_data", {24'd0, data}, 32'h00);
        chk("reset_rcv",  {31'd0, rcv},  32'd0);
        chk("reset_ferr", {31'd0, ferr}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single ideal frame 0x48
        clear_mon();
        win_lo   = cyc + 3;
        win_hi   = cyc + LAT - 1;
        busy_low = 0;
        send_frame(8'h48, BAUD, 1'b1, 0, t0);
        repeat (5) @(negedge clk);
        chk("h48_count", rcv_d.size(), 32'd1);
        if (rcv_d.size() > 0) begin
            chk("h48_data", {24'd0, rcv_d[0]}, 32'h48);
            chk("h48_latency", rcv_t[0] - t0, LAT);
        end
        chk("h48_busy_low", busy_low, 32'd0);
        chk("h48_ferr", ferr_n, 32'd0);
        win_lo = -1;
        win_hi = -1;

        // Back-to-back 0x55 then 0xAA
        clear_mon();
        send_frame(8'h55, BAUD, 1'b1, 0, t0);
        send_frame(8'hAA, BAUD, 1'b1, 0, t1);
        repeat (5) @(negedge clk);
        chk("b2b_count", rcv_d.size(), 32'd2);
        if (rcv_d.size() == 2) begin
            chk("b2b_data0", {24'd0, rcv_d[0]}, 32'h55);
            chk("b2b_data1", {24'd0, rcv_d[1]}, 32'hAA);
            chk("b2b_spacing", rcv_t[1] - rcv_t[0], 10 * BAUD);
        end
        chk("b2b_ferr", ferr_n, 32'd0);

        // Glitch: 20 cycles low
        clear_mon();
        t0 = cyc;
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (34) @(negedge clk);
        chk("glitch_busy_before_tick", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("glitch_busy_after_tick", {31'd0, busy}, 32'd0);
        repeat (10) @(negedge clk);
        chk("glitch_no_rcv", rcv_d.size(), 32'd0);
        chk("glitch_no_ferr", ferr_n, 32'd0);
        send_frame(8'h31, BAUD, 1'b1, 0, t0);
        repeat (5) @(negedge clk);
        chk("h31_count", rcv_d.size(), 32'd1);
        chk("h31_data", {24'd0, data}, 32'h31);

        // Framing error: 0x7E, stop low, held low 3 more bit times
        clear_mon();
        send_frame(8'h7E, BAUD, 1'b0, 3 * BAUD, t0);
        // rx was just released; the receiver has not seen it yet
        chk("ferr_busy_held", {31'd0, busy}, 32'd1);
        repeat (5) @(negedge clk);
        chk("ferr_busy_release", {31'd0, busy}, 32'd0);
        chk("ferr_count", ferr_n, 32'd1);
        chk("ferr_no_rcv", rcv_d.size(), 32'd0);
        chk("ferr_data_kept", {24'd0, data}, 32'h31);
        send_frame(8'h0F, BAUD, 1'b1, 0, t0);
        repeat (5) @(negedge clk);
        chk("h0f_count", rcv_d.size(), 32'd1);
        chk("h0f_data", {24'd0, data}, 32'h0F);

        // Reset during data bit 3 of 0xC3
        clear_mon();
        b  = 8'hC3;
        rx = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            repeat (BAUD) @(negedge clk);
        end
        rx = b[3];
        repeat (BAUD / 2) @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data", {24'd0, data}, 32'h00);
        chk("rst_rcv",  {31'd0, rcv},  32'd0);
        chk("rst_ferr", {31'd0, ferr}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        repeat (11 * BAUD) @(negedge clk);
        chk("rst_no_rcv", rcv_d.size(), 32'd0);
        chk("rst_no_ferr", ferr_n, 32'd0);
        send_frame(8'h5A, BAUD, 1'b1, 0, t0);
        repeat (5) @(negedge clk);
        chk("h5a_count", rcv_d.size(), 32'd1);
        chk("h5a_data", {24'd0, data}, 32'h5A);

        // Baud tolerance: 0xA5 at -3% and +3%
        clear_mon();
        send_frame(8'hA5, BAUD - 3, 1'b1, 0, t0);
        repeat (5) @(negedge clk);
        chk("slowfast_m3_count", rcv_d.size(), 32'd1);
        chk("slowfast_m3_data", {24'd0, data}, 32'hA5);
        clear_mon();
        send_frame(8'hA5, BAUD + 3, 1'b1, 0, t0);
        repeat (5) @(negedge clk);
        chk("slowfast_p3_count", rcv_d.size(), 32'd1);
        chk("slowfast_p3_data", {24'd0, data}, 32'hA5);

        // Random frames against a queue model of sent bytes
        clear_mon();
        exp_q.delete();
        for (int k = 0; k < 8; k++) begin
            b   = 8'($urandom_range(0, 255));
            per = $urandom_range(BAUD - 2, BAUD + 2);
            gap = $urandom_range(0, 4);
            send_frame(b, per, 1'b1, 0, t0);
            exp_q.push_back(b);
            repeat (gap) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        chk("rand_count", rcv_d.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < rcv_d.size(); k++) begin
            chk($sformatf("rand_data%0d", k), {24'd0, rcv_d[k]}, {24'd0, exp_q[k]});
        end
        chk("rand_ferr", ferr_n, 32'd0);

        chk("rcv_ferr_exclusive", both_n, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver. Consumes the serial line driven by the team's UART transmitter stages.
- Recovers each byte by mid-bit sampling, timed by a baud divisor from baudgen.vh.
- Presents the byte with a one-cycle valid strobe, plus a framing-error strobe.
- Sits between the external rx pin and any byte consumer (echo logic, LED register, FIFO).

Parameters:
- BAUD, default `B115200 (104 at 12 MHz): clock cycles per serial bit. Must be ≥ 4.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input; idles high.
- data  out  8  last correctly received byte.
- rcv  out  1  one-cycle pulse when data is updated.
- ferr  out  1  one-cycle pulse when the stop bit is sampled low.
- busy  out  1  high while a frame is being received, from start detect to end of stop.

Behaviour:
- Reset values: data=0x00, rcv=0, ferr=0, busy=0, both synchronizer flops=1, state=IDLE, counters=0.
- Synchronizer:
  - rx passes through 2 flops; rx_s is the second flop's output.
  - All decisions use rx_s, so there are 2 cycles of input latency.
- Timing counter:
  - Loaded on each state entry, decrements every cycle.
  - "Tick" is the cycle the counter reaches 0.
  - Counter width is clog2(BAUD)+1.
- States and transitions:
  - IDLE:
    - busy=0.
    - rx_s==0 → START; load BAUD/2-1 (integer division); busy=1 from the next cycle.
  - START:
    - On tick, rx_s==0 → DATA; load BAUD-1; bit index=0.
    - On tick, rx_s==1 → IDLE (glitch rejected). No strobe.
  - DATA:
    - On each tick, shift rx_s into the shift register MSB, shifting right, so the byte is LSB-first.
    - Reload BAUD-1 and increment the index.
    - After the 8th sample → STOP; load BAUD-1.
  - STOP:
    - On tick, rx_s==1: data←shift register, rcv=1 for the next cycle only → IDLE.
    - On tick, rx_s==0: ferr=1 for one cycle; data unchanged; rcv stays 0 → BREAK.
  - BREAK:
    - busy=1.
    - Wait for rx_s==1, then → IDLE. A held-low line never produces further frames.
- Sample points, in cycles after the first cycle rx_s==0 is seen in IDLE:
  - start check at BAUD/2;
  - data bit i at BAUD/2 + (i+1)·BAUD;
  - stop bit at BAUD/2 + 9·BAUD.
  - rcv/ferr assert on the cycle after the stop sample.
- Back-to-back frames:
  - IDLE is re-entered half a bit before the stop-bit end.
  - A start bit immediately following the stop is therefore detected with no lost frame.
- rcv and ferr are never high together. data holds its value between frames.
- rst mid-frame:
  - Abort immediately to reset values.
  - If rx is still low after reset, the synchronizer must settle first. A low rx_s in IDLE then starts a new frame; the bench must only check that no rcv occurs for the aborted byte.

Test Plan:
- BAUD=104; send 0x48 as 8N1 with ideal timing.
  - Expected: exactly one rcv pulse, with data=0x48 in that cycle.
  - rcv occurs BAUD/2+9·BAUD+1 cycles after rx_s falls.
  - busy high throughout; ferr stays 0.
- Back-to-back 0x55 then 0xAA, no idle gap.
  - Expected: two rcv pulses exactly 10·BAUD cycles apart; data 0x55 then 0xAA.
- Glitch: rx low for 20 cycles, then high.
  - Expected: no rcv, no ferr; busy drops at the start-check tick; a following 0x31 frame is received correctly.
- Framing error: send 0x7E with stop bit = 0, holding rx low for 3 further bit times.
  - Expected: ferr pulses once; data keeps its previous value (0x31); no rcv.
  - busy stays high until rx returns high; the next frame 0x0F is then received.
- Reset mid-frame: assert rst during data bit 3 of 0xC3, then release with rx high.
  - Expected: all outputs at reset values; no rcv for 0xC3; the next frame 0x5A is received.
- Baud tolerance: send 0xA5 at bit period BAUD±3%.
  - Expected: data=0xA5 with one rcv for both −3% and +3%.
